sobol_sched: RTL
================

# sobol_sched

Sequencer that drives the combinational Sobol generator (`sobol`) over a block of paths. It steps path index N and dimension `dim` in path-major order, with all M dimensions of one path before moving to the next path. Each draw is registered into a one-deep output stage with valid/ready backpressure. It sits between the run controller, which issues `start` plus a path range, and the LSM path-simulation pipeline, which consumes Q0.32 draws with path/dimension tags.

## Interface
Parameters:
- `M`, 50: number of Sobol dimensions (time steps); must match the attached `sobol`.
- `DW`, `$clog2(M)`: width of dimension fields (derived; not overridden).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  cancel current run; returns to IDLE without `done`.
- `n_base`  in  32  first path index of the run.
- `n_paths`  in  32  number of paths in the run; 0 is legal.
- `sobol_n`  out  32  path index presented to `sobol.N`.
- `sobol_dim`  out  DW  dimension presented to `sobol.dim`.
- `sobol_in`  in  32  `sobol.sobol_out`; combinational from `sobol_n`/`sobol_dim`.
- `out_valid`  out  1  output register holds a draw.
- `out_ready`  in  1  consumer accepts the draw this cycle.
- `out_data`  out  32  Q0.32 draw.
- `out_path`  out  32  path index of `out_data`.
- `out_dim`  out  DW  dimension of `out_data`.
- `out_last`  out  1  `out_data` is the final draw of the run.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse at normal run completion.

## Operation
- FSM states:
  - **IDLE**: waits for `start`.
  - **RUN**: issues draws.
  - **DRAIN**: last draw issued, waiting for acceptance.
  - **DONE**: single cycle that pulses `done`.
- IDLE, `start`=1, `n_paths`!=0: latch `path_ctr`<=`n_base`, `dim_ctr`<=0, `remaining`<=`n_paths`. Go to RUN.
- IDLE, `start`=1, `n_paths`=0: go to DONE directly. No draw is issued.
- `sobol_n`=`path_ctr`, `sobol_dim`=`dim_ctr`, both driven from registers.
- RUN, load condition `!out_valid || out_ready`, on the edge:
  - `out_data`<=`sobol_in`, `out_path`<=`path_ctr`, `out_dim`<=`dim_ctr`, `out_valid`<=1.
  - Counter advance: if `dim_ctr`==M-1, then `dim_ctr`<=0, `path_ctr`<=`path_ctr`+1 (mod 2^32, wraps 0xFFFFFFFF->0), `remaining`<=`remaining`-1. Otherwise `dim_ctr`<=`dim_ctr`+1.
  - If this load is the last draw (`dim_ctr`==M-1 and `remaining`==1): `out_last`<=1, go to DRAIN.
- RUN, load condition false: output registers and counters hold.
- Output stability: while `out_valid`=1 and `out_ready`=0, `out_data`/`out_path`/`out_dim`/`out_last` are held stable.
- DRAIN, `out_valid && out_ready`: clear `out_valid` and `out_last`, go to DONE.
- DONE: `done`=1 for that cycle, then IDLE.
- `start` outside IDLE is ignored.
- `abort` in RUN or DRAIN: next edge clears `out_valid`/`out_last` and returns to IDLE. No `done`. A draw handshaken in the same cycle counts as accepted. `abort` has priority over the load and over the DRAIN transition.
- `abort` in IDLE or DONE is ignored.
- `rst` (any state, including mid-run): state IDLE, all counters 0.
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `out_path`=0, `out_dim`=0, `sobol_n`=0, `sobol_dim`=0, `busy`=0, `done`=0.

## Timing
- A `start` accepted at edge t gives the first `out_valid`=1 in the cycle after edge t+1.
- Throughput is 1 draw/cycle while `out_ready`=1. There are no bubbles between paths.
- With `out_ready` held at 1, a run of P paths: last handshake occurs in cycle t+P·M, `done` in cycle t+P·M+1, IDLE from cycle t+P·M+2.
- Critical path: `path_ctr`/`dim_ctr` regs -> `sobol` XOR tree -> `out_data` reg. This is one full cycle; no other logic sits in that path.
- `busy` is registered-state decode: 1 in RUN/DRAIN, 0 in IDLE/DONE.

## Test plan
- Basic run. Setup: M=4, `n_base`=1, `n_paths`=3, `out_ready`=1, dim 0 loaded with standard directions (v_k=1<<(31-k)).
  - Required: 12 draws in order (1,0..3),(2,0..3),(3,0..3).
  - Dim-0 values: 0x80000000, 0xC0000000, 0x40000000.
  - `out_last` only on (3,3); `done` one cycle later.
- Backpressure. Setup: same run, `out_ready` toggled pseudo-randomly.
  - Required: identical 12-draw sequence, no drop or duplicate.
  - Outputs stable while `valid && !ready`.
- Empty and ignored starts:
  - `n_paths`=0 -> `done` pulse one cycle after `start`, `out_valid` never high.
  - `start` during RUN -> ignored, counters unaffected.
- Wrap-around. Setup: `n_base`=0xFFFFFFFF, `n_paths`=2.
  - Required: `out_path` goes 0xFFFFFFFF for dims 0..M-1, then 0x00000000.
  - `done` asserted normally.
- Abort and reset. Setup: assert `abort` after the 5th handshake with `out_ready`=0.
  - Required: `out_valid` drops next cycle, no `done`, IDLE.
  - A new `start` then produces draws from the new `n_base`, dim 0.
  - Repeat with `rst` mid-DRAIN: all outputs at reset values next cycle.

Source files
------------

// File: rtl/sobol_sched.sv
// Path-major sequencer for the combinational Sobol generator: walks (path, dim)
// over a block of paths and registers each draw into a one-deep valid/ready stage.
module sobol_sched #(
    parameter int M  = 50,
    parameter int DW = $clog2(M)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [31:0]   n_base,
    input  logic [31:0]   n_paths,
    output logic [31:0]   sobol_n,
    output logic [DW-1:0] sobol_dim,
    input  logic [31:0]   sobol_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic [31:0]   out_path,
    output logic [DW-1:0] out_dim,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    // state | meaning
    // IDLE  | waiting for start
    // RUN   | issuing draws, one per accepted slot
    // DRAIN | final draw loaded, waiting for the consumer to take it
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   path_ctr;
    logic [DW-1:0] dim_ctr;
    logic [31:0]   remaining;

    logic          accept;
    logic          load;
    logic          clr_out;
    logic          dim_wrap;
    logic          is_last;

    assign dim_wrap  = (dim_ctr == DW'(M - 1));
    assign is_last   = dim_wrap && (remaining == 32'd1);

    assign sobol_n   = path_ctr;
    assign sobol_dim = dim_ctr;
    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort outranks both the load in RUN and the handshake exit from DRAIN
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load      = 1'b0;
        clr_out   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (n_paths == 32'd0) begin
                        state_nxt = DONE;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    clr_out   = 1'b1;
                    state_nxt = IDLE;
                end else if (!out_valid || out_ready) begin
                    load = 1'b1;
                    if (is_last) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    clr_out   = 1'b1;
                    state_nxt = IDLE;
                end else if (out_valid && out_ready) begin
                    clr_out   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            path_ctr  <= 32'd0;
            dim_ctr   <= '0;
            remaining <= 32'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= 32'd0;
            out_path  <= 32'd0;
            out_dim   <= '0;
        end else begin
            if (accept) begin
                path_ctr  <= n_base;
                dim_ctr   <= '0;
                remaining <= n_paths;
            end
            if (load) begin
                out_data  <= sobol_in;
                out_path  <= path_ctr;
                out_dim   <= dim_ctr;
                out_valid <= 1'b1;
                out_last  <= is_last;
                if (dim_wrap) begin
                    dim_ctr   <= '0;
                    path_ctr  <= path_ctr + 32'd1;
                    remaining <= remaining - 32'd1;
                end else begin
                    dim_ctr <= dim_ctr + DW'(1);
                end
            end
            if (clr_out) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
